// File: rtl/autocomplete_scheduler.sv
// rtl/autocomplete_scheduler.sv - sweeps the Trax board through the forced-move evaluator until stable
module autocomplete_scheduler #(
    parameter int MAX_ROW    = 50,
    parameter int MAX_COL    = 50,
    parameter int MAX_SWEEPS = 16,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [9:0]       n,
    input  logic [9:0]       m,
    output logic             busy,
    output logic             done,
    output logic             limit_hit,
    output logic [CNT_W-1:0] changes_count,
    output logic [4:0]       sweep_count,
    output logic             mem_rd_en,
    output logic [9:0]       mem_rd_row,
    output logic [9:0]       mem_rd_col,
    input  logic [2:0]       mem_rd_data,
    output logic             mem_wr_en,
    output logic [9:0]       mem_wr_row,
    output logic [9:0]       mem_wr_col,
    output logic [2:0]       mem_wr_data,
    output logic [2:0]       eval_curr,
    output logic [2:0]       eval_up,
    output logic [2:0]       eval_right,
    output logic [2:0]       eval_down,
    output logic [2:0]       eval_left,
    output logic [9:0]       eval_i,
    output logic [9:0]       eval_j,
    output logic [9:0]       eval_n,
    output logic [9:0]       eval_m,
    input  logic             eval_changed,
    input  logic [2:0]       eval_out_cell
);

    localparam logic [9:0] ROW_CAP  = 10'(MAX_ROW);
    localparam logic [9:0] COL_CAP  = 10'(MAX_COL);
    localparam logic [4:0] SWEEP_CAP = 5'(MAX_SWEEPS);

    // SAMPLE is the cycle after EVAL, where the evaluator result is taken
    typedef enum logic [3:0] {
        IDLE, RD_CUR, RD_N, RD_E, RD_S, RD_W, EVAL, SAMPLE, WRITE, NEXT, DONE
    } state_t;

    state_t state, state_nxt;

    logic [9:0]       i_r, j_r;
    logic [9:0]       n_eff, m_eff;
    logic [2:0]       wr_cell;
    logic             sweep_dirty;
    logic [CNT_W-1:0] chg_r;
    logic [4:0]       swp_r;
    logic             lim_r;

    logic [10:0] i_p1, j_p1;
    logic        has_n, has_s, has_e, has_w;
    logic        last_row, last_col, last_cell;
    logic [4:0]  swp_inc;
    logic [9:0]  n_clip, m_clip;

    assign i_p1      = {1'b0, i_r} + 11'd1;
    assign j_p1      = {1'b0, j_r} + 11'd1;
    assign has_n     = (i_r != 10'd0);
    assign has_w     = (j_r != 10'd0);
    assign has_s     = (i_p1 < {1'b0, n_eff});
    assign has_e     = (j_p1 < {1'b0, m_eff});
    assign last_row  = (i_p1 == {1'b0, n_eff});
    assign last_col  = (j_p1 == {1'b0, m_eff});
    assign last_cell = last_row && last_col;
    assign swp_inc   = swp_r + 5'd1;
    assign n_clip    = (n > ROW_CAP) ? ROW_CAP : n;
    assign m_clip    = (m > COL_CAP) ? COL_CAP : m;

    assign limit_hit     = lim_r;
    assign changes_count = chg_r;
    assign sweep_count   = swp_r;
    assign eval_i        = i_r;
    assign eval_j        = j_r;
    assign eval_n        = n_eff;
    assign eval_m        = m_eff;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n == 10'd0 || m == 10'd0) ? DONE : RD_CUR;
                end
            end
            RD_CUR: state_nxt = RD_N;
            RD_N:   state_nxt = (mem_rd_data != 3'b000) ? NEXT : RD_E;
            RD_E:   state_nxt = RD_S;
            RD_S:   state_nxt = RD_W;
            RD_W:   state_nxt = EVAL;
            EVAL:   state_nxt = SAMPLE;
            SAMPLE: state_nxt = eval_changed ? WRITE : NEXT;
            WRITE:  state_nxt = NEXT;
            NEXT: begin
                if (last_cell && (!sweep_dirty || swp_inc == SWEEP_CAP)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD_CUR;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: scan position, captured neighbours, sweep bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_r         <= '0;
            j_r         <= '0;
            n_eff       <= '0;
            m_eff       <= '0;
            wr_cell     <= '0;
            sweep_dirty <= 1'b0;
            chg_r       <= '0;
            swp_r       <= '0;
            lim_r       <= 1'b0;
            eval_curr   <= '0;
            eval_up     <= '0;
            eval_right  <= '0;
            eval_down   <= '0;
            eval_left   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_eff       <= n_clip;
                        m_eff       <= m_clip;
                        i_r         <= '0;
                        j_r         <= '0;
                        chg_r       <= '0;
                        swp_r       <= '0;
                        lim_r       <= 1'b0;
                        sweep_dirty <= 1'b0;
                    end
                end
                RD_N:   eval_curr  <= mem_rd_data;
                RD_E:   eval_down  <= has_n ? mem_rd_data : 3'b000;
                RD_S:   eval_right <= has_e ? mem_rd_data : 3'b000;
                RD_W:   eval_up    <= has_s ? mem_rd_data : 3'b000;
                EVAL:   eval_left  <= has_w ? mem_rd_data : 3'b000;
                SAMPLE: wr_cell    <= eval_out_cell;
                WRITE: begin
                    sweep_dirty <= 1'b1;
                    if (chg_r != {CNT_W{1'b1}}) begin
                        chg_r <= chg_r + 1'b1;
                    end
                end
                NEXT: begin
                    if (last_cell) begin
                        swp_r <= swp_inc;
                        if (sweep_dirty) begin
                            if (swp_inc == SWEEP_CAP) begin
                                lim_r <= 1'b1;
                            end else begin
                                sweep_dirty <= 1'b0;
                                i_r         <= '0;
                                j_r         <= '0;
                            end
                        end
                    end else if (last_col) begin
                        j_r <= '0;
                        i_r <= i_p1[9:0];
                    end else begin
                        j_r <= j_p1[9:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: RAM strobes/addresses, busy and done
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_row  = '0;
        mem_rd_col  = '0;
        mem_wr_en   = 1'b0;
        mem_wr_row  = '0;
        mem_wr_col  = '0;
        mem_wr_data = '0;
        case (state)
            RD_CUR: begin
                busy       = 1'b1;
                mem_rd_en  = 1'b1;
                mem_rd_row = i_r;
                mem_rd_col = j_r;
            end
            RD_N: begin
                busy      = 1'b1;
                mem_rd_en = has_n;
                if (has_n) begin
                    mem_rd_row = i_r - 10'd1;
                    mem_rd_col = j_r;
                end
            end
            RD_E: begin
                busy      = 1'b1;
                mem_rd_en = has_e;
                if (has_e) begin
                    mem_rd_row = i_r;
                    mem_rd_col = j_p1[9:0];
                end
            end
            RD_S: begin
                busy      = 1'b1;
                mem_rd_en = has_s;
                if (has_s) begin
                    mem_rd_row = i_p1[9:0];
                    mem_rd_col = j_r;
                end
            end
            RD_W: begin
                busy      = 1'b1;
                mem_rd_en = has_w;
                if (has_w) begin
                    mem_rd_row = i_r;
                    mem_rd_col = j_r - 10'd1;
                end
            end
            EVAL, SAMPLE, NEXT: busy = 1'b1;
            WRITE: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_wr_row  = i_r;
                mem_wr_col  = j_r;
                mem_wr_data = wr_cell;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_autocomplete_scheduler.sv
// tb/tb_autocomplete_scheduler.sv - directed self-checking bench for autocomplete_scheduler
module tb_autocomplete_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  n, m;
    logic        busy, done, limit_hit;
    logic [11:0] changes_count;
    logic [4:0]  sweep_count;
    logic        mem_rd_en, mem_wr_en;
    logic [9:0]  mem_rd_row, mem_rd_col, mem_wr_row, mem_wr_col;
    logic [2:0]  mem_rd_data, mem_wr_data;
    logic [2:0]  eval_curr, eval_up, eval_right, eval_down, eval_left;
    logic [9:0]  eval_i, eval_j, eval_n, eval_m;
    logic        eval_changed;
    logic [2:0]  eval_out_cell;

    autocomplete_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .m(m),
        .busy(busy), .done(done), .limit_hit(limit_hit),
        .changes_count(changes_count), .sweep_count(sweep_count),
        .mem_rd_en(mem_rd_en), .mem_rd_row(mem_rd_row), .mem_rd_col(mem_rd_col),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_row(mem_wr_row), .mem_wr_col(mem_wr_col),
        .mem_wr_data(mem_wr_data),
        .eval_curr(eval_curr), .eval_up(eval_up), .eval_right(eval_right),
        .eval_down(eval_down), .eval_left(eval_left),
        .eval_i(eval_i), .eval_j(eval_j), .eval_n(eval_n), .eval_m(eval_m),
        .eval_changed(eval_changed), .eval_out_cell(eval_out_cell)
    );

    always #5 clk = ~clk;

    // Board RAM model with bulk fill and single-cell poke
    logic [2:0] mem [0:49][0:49];
    logic       fill_en = 1'b0, poke_en = 1'b0;
    logic [2:0] fill_val = 3'b000, poke_val = 3'b000;
    int         poke_r = 0, poke_c = 0;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int r = 0; r < 50; r++)
                for (int c = 0; c < 50; c++)
                    mem[r][c] <= fill_val;
        end else if (poke_en) begin
            mem[poke_r][poke_c] <= poke_val;
        end else if (mem_wr_en && mem_wr_row < 10'd50 && mem_wr_col < 10'd50) begin
            mem[mem_wr_row][mem_wr_col] <= mem_wr_data;
        end
        if (mem_rd_en && mem_rd_row < 10'd50 && mem_rd_col < 10'd50)
            mem_rd_data <= mem[mem_rd_row][mem_rd_col];
        else if (mem_rd_en)
            mem_rd_data <= 3'b000;
    end

    // Evaluator model: 0 never forces, 1 forces 101 on one exact neighbourhood, 2 always forces 000
    int eval_mode = 0;
    always_comb begin
        eval_changed  = 1'b0;
        eval_out_cell = 3'b000;
        case (eval_mode)
            1: begin
                if (eval_curr == 3'b000 && eval_up == 3'b010 && eval_down == 3'b100 &&
                    eval_left == 3'b110 && eval_right == 3'b111) begin
                    eval_changed  = 1'b1;
                    eval_out_cell = 3'b101;
                end
            end
            2: eval_changed = 1'b1;
            default: ;
        endcase
    end

    // Bus monitor, sampled mid-cycle
    int lim_n = 50, lim_m = 50;
    int rd_total = 0, wr_total = 0, busy_total = 0, done_total = 0;
    int oob_total = 0, both_total = 0, corner_total = 0;
    logic [9:0] last_wr_row = '0, last_wr_col = '0;
    logic [2:0] last_wr_data = '0;
    logic [2:0] w_up = '0, w_down = '0, w_left = '0, w_right = '0, w_curr = '0;

    always @(negedge clk) begin
        if (mem_rd_en) rd_total <= rd_total + 1;
        if (mem_rd_en && (int'(mem_rd_row) >= lim_n || int'(mem_rd_col) >= lim_m))
            oob_total <= oob_total + 1;
        if (mem_rd_en && mem_rd_row == 10'd49 && mem_rd_col == 10'd49)
            corner_total <= corner_total + 1;
        if (mem_rd_en && mem_wr_en) both_total <= both_total + 1;
        if (busy) busy_total <= busy_total + 1;
        if (done) done_total <= done_total + 1;
        if (mem_wr_en) begin
            wr_total     <= wr_total + 1;
            last_wr_row  <= mem_wr_row;
            last_wr_col  <= mem_wr_col;
            last_wr_data <= mem_wr_data;
            w_up         <= eval_up;
            w_down       <= eval_down;
            w_left       <= eval_left;
            w_right      <= eval_right;
            w_curr       <= eval_curr;
        end
    end

    int n_assert = 0, n_fail = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [2:0] v);
        @(posedge clk); #1;
        fill_val = v; fill_en = 1'b1;
        @(posedge clk); #1;
        fill_en = 1'b0;
    endtask

    task automatic poke(input int r, input int c, input logic [2:0] v);
        @(posedge clk); #1;
        poke_r = r; poke_c = c; poke_val = v; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic run_pass(input logic [9:0] nn, input logic [9:0] mm, input int budget, output int lat);
        @(posedge clk); #1;
        n = nn; m = mm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        expect_eq("done_seen", {31'b0, lat != 0}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic setup_force_board();
        fill(3'b011);
        poke(0, 1, 3'b100);
        poke(1, 0, 3'b110);
        poke(1, 1, 3'b000);
        poke(1, 2, 3'b111);
        poke(2, 1, 3'b010);
    endtask

    int lat, rd0, wr0, busy0, done0, oob0, corner0, k_wr;

    initial begin
        rst = 1'b1; start = 1'b0; n = '0; m = '0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("reset_ctrl", {busy, done, limit_hit, mem_rd_en, mem_wr_en}, 32'd0);
        expect_eq("reset_eval", {eval_curr, eval_up, eval_right, eval_down, eval_left}, 32'd0);
        expect_eq("reset_cnt", {changes_count, sweep_count}, 32'd0);
        rst = 1'b0;

        // Full 3x3 occupied board: one clean sweep at 3 cycles per cell
        lim_n = 3; lim_m = 3; eval_mode = 0;
        fill(3'b011);
        busy0 = busy_total; wr0 = wr_total;
        run_pass(10'd3, 10'd3, 200, lat);
        expect_eq("full_lat", lat, 32'd28);
        expect_eq("full_busy", busy_total - busy0, 32'd27);
        expect_eq("full_sweeps", sweep_count, 32'd1);
        expect_eq("full_changes", changes_count, 32'd0);
        expect_eq("full_writes", wr_total - wr0, 32'd0);

        // 3x3 with (1,1) empty and a forcing neighbourhood
        eval_mode = 1;
        setup_force_board();
        busy0 = busy_total; wr0 = wr_total;
        run_pass(10'd3, 10'd3, 300, lat);
        expect_eq("force_lat", lat, 32'd61);
        expect_eq("force_busy", busy_total - busy0, 32'd60);
        expect_eq("force_writes", wr_total - wr0, 32'd1);
        expect_eq("force_wr_addr", {last_wr_row, last_wr_col}, {10'd1, 10'd1});
        expect_eq("force_wr_data", last_wr_data, 32'd5);
        expect_eq("force_nbrs", {w_curr, w_up, w_down, w_left, w_right},
                  {3'b000, 3'b010, 3'b100, 3'b110, 3'b111});
        expect_eq("force_board", mem[1][1], 32'd5);
        expect_eq("force_sweeps", sweep_count, 32'd2);
        expect_eq("force_changes", changes_count, 32'd1);

        // Zero-row pass goes straight to DONE and clears the counters
        rd0 = rd_total; wr0 = wr_total; busy0 = busy_total;
        run_pass(10'd0, 10'd5, 20, lat);
        expect_eq("zero_lat", lat, 32'd1);
        expect_eq("zero_ram", (rd_total - rd0) + (wr_total - wr0), 32'd0);
        expect_eq("zero_busy", busy_total - busy0, 32'd0);
        expect_eq("zero_cnts", {changes_count, sweep_count}, 32'd0);

        // 2x2 with empty (0,0): no out-of-range reads, edge neighbours read as empty
        lim_n = 2; lim_m = 2; eval_mode = 0;
        fill(3'b011);
        poke(0, 0, 3'b000);
        rd0 = rd_total; oob0 = oob_total; busy0 = busy_total;
        run_pass(10'd2, 10'd2, 100, lat);
        expect_eq("corner_oob", oob_total - oob0, 32'd0);
        expect_eq("corner_reads", rd_total - rd0, 32'd8);
        expect_eq("corner_busy", busy_total - busy0, 32'd17);
        expect_eq("corner_dl", {eval_down, eval_left}, 32'd0);
        expect_eq("corner_ur", {eval_up, eval_right}, {3'b011, 3'b011});

        // Oversized request is clipped to 50x50
        lim_n = 50; lim_m = 50;
        fill(3'b011);
        oob0 = oob_total; corner0 = corner_total; busy0 = busy_total;
        run_pass(10'd60, 10'd60, 9000, lat);
        expect_eq("big_dims", {eval_n, eval_m}, {10'd50, 10'd50});
        expect_eq("big_busy", busy_total - busy0, 32'd7500);
        expect_eq("big_oob", oob_total - oob0, 32'd0);
        expect_eq("big_corner", {31'b0, (corner_total - corner0) != 0}, 32'd1);

        // Evaluator always changed on a 1x1 board: runs into the sweep limit
        lim_n = 1; lim_m = 1; eval_mode = 2;
        fill(3'b000);
        wr0 = wr_total; busy0 = busy_total;
        run_pass(10'd1, 10'd1, 400, lat);
        expect_eq("limit_sweeps", sweep_count, 32'd16);
        expect_eq("limit_hit", limit_hit, 32'd1);
        expect_eq("limit_changes", changes_count, 32'd16);
        expect_eq("limit_busy", busy_total - busy0, 32'd144);

        // Reset during WRITE aborts without the write landing
        lim_n = 3; lim_m = 3; eval_mode = 1;
        setup_force_board();
        done0 = done_total;
        @(posedge clk); #1;
        n = 10'd3; m = 10'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k_wr = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (mem_wr_en) begin
                k_wr = k;
                break;
            end
        end
        expect_eq("rst_wr_seen", {31'b0, k_wr != 0}, 32'd1);
        #1 rst = 1'b1;
        #1;
        expect_eq("rst_async_ctrl", {busy, done, limit_hit, mem_rd_en, mem_wr_en}, 32'd0);
        expect_eq("rst_async_data", {mem_wr_data, eval_curr, eval_up, eval_down, changes_count, sweep_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_no_write", mem[1][1], 32'd0);
        expect_eq("rst_no_done", done_total - done0, 32'd0);
        run_pass(10'd3, 10'd3, 300, lat);
        expect_eq("rst_rerun_changes", changes_count, 32'd1);
        expect_eq("rst_rerun_board", mem[1][1], 32'd5);

        // start held high through a pass: exactly one done, limit_hit cleared
        eval_mode = 0;
        fill(3'b011);
        done0 = done_total; busy0 = busy_total;
        @(posedge clk); #1;
        n = 10'd3; m = 10'd3; start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        expect_eq("hold_done_seen", {31'b0, lat != 0}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        expect_eq("hold_dones", done_total - done0, 32'd1);
        expect_eq("hold_busy", busy_total - busy0, 32'd27);
        expect_eq("hold_limit_clr", limit_hit, 32'd0);

        expect_eq("rd_wr_overlap", both_total, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
